// File: rtl/rf_pkg.sv
// Shared types and default dimensions for the multi-port register file.
`timescale 1ns/1ps
package rf_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } rf_clr_state_t;

    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 16;
    localparam int RF_PC_IDX   = 15;

endpackage

// File: rtl/register_file_mp_if.sv
// Bus between the pipeline and the register file: read ports, two write ports,
// scoreboard set and soft-clear control.
`timescale 1ns/1ps
interface register_file_mp_if
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = 3
) ();
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     we0;
    logic [AW-1:0]            wa0;
    logic [DATA_W-1:0]        wd0;
    logic                     we1;
    logic [AW-1:0]            wa1;
    logic [DATA_W-1:0]        wd1;
    logic [DATA_W-1:0]        pc_in;
    logic                     pend_set;
    logic [AW-1:0]            pend_addr;
    logic                     clr_start;
    logic                     clr_busy;

    modport master (
        output rd_addr, we0, wa0, wd0, we1, wa1, wd1, pc_in,
               pend_set, pend_addr, clr_start,
        input  rd_data, rd_busy, clr_busy
    );

    modport slave (
        input  rd_addr, we0, wa0, wd0, we1, wa1, wd1, pc_in,
               pend_set, pend_addr, clr_start,
        output rd_data, rd_busy, clr_busy
    );
endinterface

// File: rtl/rf_clear_fsm.sv
// Soft-clear sequencer: once started, walks every register index exactly once,
// one index per cycle, and cannot be retriggered until it finishes.
`timescale 1ns/1ps
module rf_clear_fsm
    import rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_start,
    output logic                        clr_busy,
    output logic                        clr_we,
    output logic [$clog2(NUM_REGS)-1:0] clr_addr
);
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    rf_clr_state_t state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        clr_busy = (state_q == SWEEP);
        clr_we   = (state_q == SWEEP);
        clr_addr = cnt_q;
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with dual writeback, optional read bypass,
// load-pending scoreboard and a sequential soft-clear sweep.
`timescale 1ns/1ps
module register_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = 3,
    parameter int PC_IDX   = RF_PC_IDX,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    register_file_mp_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

    logic          clr_busy;
    logic          clr_we;
    logic [AW-1:0] clr_addr;

    rf_clear_fsm #(
        .NUM_REGS (NUM_REGS)
    ) u_clear_fsm (
        .clk       (clk),
        .rst       (rst),
        .clr_start (bus.clr_start),
        .clr_busy  (clr_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    // The sweep owns the array while busy; PC slot is never architecturally written.
    logic we0_ok, we1_ok, pset_ok;
    assign we0_ok  = bus.we0      && !clr_busy && (bus.wa0 != PC_A);
    assign we1_ok  = bus.we1      && !clr_busy && (bus.wa1 != PC_A);
    assign pset_ok = bus.pend_set && !clr_busy && (bus.pend_addr != PC_A);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              pend_q [NUM_REGS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [AW-1:0] IDX = AW'(gi);
            logic [DATA_W-1:0] reg_d;
            logic              pend_d;

            always_comb begin
                reg_d  = regs_q[gi];
                pend_d = pend_q[gi];
                if (clr_we && (clr_addr == IDX)) begin
                    reg_d  = '0;
                    pend_d = 1'b0;
                end else begin
                    if (we1_ok && (bus.wa1 == IDX)) begin
                        reg_d = bus.wd1;
                    end else if (we0_ok && (bus.wa0 == IDX)) begin
                        reg_d = bus.wd0;
                    end
                    if (we1_ok && (bus.wa1 == IDX)) begin
                        pend_d = 1'b0;
                    end
                    // A load issued in the same cycle as an older load returns keeps the bit set.
                    if (pset_ok && (bus.pend_addr == IDX)) begin
                        pend_d = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    regs_q[gi] <= '0;
                    pend_q[gi] <= 1'b0;
                end else begin
                    regs_q[gi] <= reg_d;
                    pend_q[gi] <= pend_d;
                end
            end
        end
    endgenerate

    logic [AW-1:0] ra [NUM_RD];
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_raddr
            assign ra[gi] = bus.rd_addr[gi*AW +: AW];
        end
    endgenerate

    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [NUM_RD-1:0]        rd_busy_c;

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data_c[i*DATA_W +: DATA_W] = regs_q[ra[i]];
            rd_busy_c[i]                  = pend_q[ra[i]];
            if (ra[i] == PC_A) begin
                rd_data_c[i*DATA_W +: DATA_W] = bus.pc_in;
                rd_busy_c[i]                  = 1'b0;
            end else if ((BYPASS != 0) && !clr_busy) begin
                if (bus.we1 && (bus.wa1 == ra[i])) begin
                    rd_data_c[i*DATA_W +: DATA_W] = bus.wd1;
                    rd_busy_c[i]                  = 1'b0;
                end else if (bus.we0 && (bus.wa0 == ra[i])) begin
                    rd_data_c[i*DATA_W +: DATA_W] = bus.wd0;
                end
            end
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.clr_busy = clr_busy;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed and randomized checks of register_file_mp (bypass on/off, 16 and 32 regs)
// against an array/scoreboard model of the architectural rules.
`timescale 1ns/1ps
module tb_register_file_mp;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int          t_addr [4];
    bit          t_we0, t_we1, t_pset, t_clr;
    int          t_wa0, t_wa1, t_paddr;
    logic [31:0] t_wd0, t_wd1, t_pc;

    register_file_mp_if #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3)) ifa ();
    register_file_mp_if #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3)) ifb ();
    register_file_mp_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(4)) ifc ();

    assign ifa.rd_addr   = {4'(t_addr[2]), 4'(t_addr[1]), 4'(t_addr[0])};
    assign ifa.we0       = t_we0;
    assign ifa.wa0       = 4'(t_wa0);
    assign ifa.wd0       = t_wd0;
    assign ifa.we1       = t_we1;
    assign ifa.wa1       = 4'(t_wa1);
    assign ifa.wd1       = t_wd1;
    assign ifa.pc_in     = t_pc;
    assign ifa.pend_set  = t_pset;
    assign ifa.pend_addr = 4'(t_paddr);
    assign ifa.clr_start = t_clr;

    assign ifb.rd_addr   = {4'(t_addr[2]), 4'(t_addr[1]), 4'(t_addr[0])};
    assign ifb.we0       = t_we0;
    assign ifb.wa0       = 4'(t_wa0);
    assign ifb.wd0       = t_wd0;
    assign ifb.we1       = t_we1;
    assign ifb.wa1       = 4'(t_wa1);
    assign ifb.wd1       = t_wd1;
    assign ifb.pc_in     = t_pc;
    assign ifb.pend_set  = t_pset;
    assign ifb.pend_addr = 4'(t_paddr);
    assign ifb.clr_start = t_clr;

    assign ifc.rd_addr   = {5'(t_addr[3]), 5'(t_addr[2]), 5'(t_addr[1]), 5'(t_addr[0])};
    assign ifc.we0       = t_we0;
    assign ifc.wa0       = 5'(t_wa0);
    assign ifc.wd0       = t_wd0;
    assign ifc.we1       = t_we1;
    assign ifc.wa1       = 5'(t_wa1);
    assign ifc.wd1       = t_wd1;
    assign ifc.pc_in     = t_pc;
    assign ifc.pend_set  = t_pset;
    assign ifc.pend_addr = 5'(t_paddr);
    assign ifc.clr_start = t_clr;

    register_file_mp #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3), .PC_IDX(15), .BYPASS(1))
        dut_a (.clk(clk), .rst(rst_n), .bus(ifa));
    register_file_mp #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3), .PC_IDX(15), .BYPASS(0))
        dut_b (.clk(clk), .rst(rst_n), .bus(ifb));
    register_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(4), .PC_IDX(31), .BYPASS(1))
        dut_c (.clk(clk), .rst(rst_n), .bus(ifc));

    // Architectural model: register contents, pending bits, remaining sweep cycles.
    logic [31:0] m_reg  [32];
    bit          m_pend [32];
    int          m_left, m_cnt, m_num, m_pc, phase;
    int          tests = 0;
    int          fails = 0;

    function automatic logic [31:0] exp_data(int a, bit byp);
        if (a == m_pc) return t_pc;
        if (byp && m_left == 0) begin
            if (t_we1 && t_wa1 == a) return t_wd1;
            if (t_we0 && t_wa0 == a) return t_wd0;
        end
        return m_reg[a];
    endfunction

    function automatic bit exp_busy(int a, bit byp);
        if (a == m_pc) return 1'b0;
        if (byp && m_left == 0 && t_we1 && t_wa1 == a) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_left = 0;
        m_cnt  = 0;
    endtask

    task automatic model_update();
        if (m_left > 0) begin
            m_reg[m_cnt]  = '0;
            m_pend[m_cnt] = 1'b0;
            m_cnt++;
            m_left--;
            if (m_left == 0) m_cnt = 0;
        end else begin
            if (t_we0 && t_wa0 != m_pc) m_reg[t_wa0] = t_wd0;
            if (t_we1 && t_wa1 != m_pc) m_reg[t_wa1] = t_wd1;
            if (t_we1) m_pend[t_wa1] = 1'b0;
            if (t_pset && t_paddr != m_pc) m_pend[t_paddr] = 1'b1;
            if (t_clr) begin
                m_left = m_num;
                m_cnt  = 0;
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", name, got, expv);
        end
    endtask

    task automatic check_all(string tag);
        bit busy_exp;
        busy_exp = (m_left > 0);
        if (phase == 0) begin
            chk($sformatf("%s a.clr_busy", tag), {31'b0, ifa.clr_busy}, {31'b0, busy_exp});
            chk($sformatf("%s b.clr_busy", tag), {31'b0, ifb.clr_busy}, {31'b0, busy_exp});
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("%s a.rd_data[%0d]", tag, i), ifa.rd_data[i*32 +: 32], exp_data(t_addr[i], 1'b1));
                chk($sformatf("%s b.rd_data[%0d]", tag, i), ifb.rd_data[i*32 +: 32], exp_data(t_addr[i], 1'b0));
                chk($sformatf("%s a.rd_busy[%0d]", tag, i), {31'b0, ifa.rd_busy[i]}, {31'b0, exp_busy(t_addr[i], 1'b1)});
                chk($sformatf("%s b.rd_busy[%0d]", tag, i), {31'b0, ifb.rd_busy[i]}, {31'b0, exp_busy(t_addr[i], 1'b0)});
            end
        end else begin
            chk($sformatf("%s c.clr_busy", tag), {31'b0, ifc.clr_busy}, {31'b0, busy_exp});
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("%s c.rd_data[%0d]", tag, i), ifc.rd_data[i*32 +: 32], exp_data(t_addr[i], 1'b1));
                chk($sformatf("%s c.rd_busy[%0d]", tag, i), {31'b0, ifc.rd_busy[i]}, {31'b0, exp_busy(t_addr[i], 1'b1)});
            end
        end
    endtask

    task automatic set_idle();
        t_we0  = 1'b0;
        t_we1  = 1'b0;
        t_pset = 1'b0;
        t_clr  = 1'b0;
    endtask

    // Inputs are applied just after a falling edge; one call = one clock transaction.
    task automatic step(string tag);
        #1;
        check_all(tag);
        $display("[TB] %-12s rd=%0d/%0d/%0d/%0d we0=%0d@%0d we1=%0d@%0d pset=%0d@%0d clr=%0d sweep_left=%0d",
                 tag, t_addr[0], t_addr[1], t_addr[2], t_addr[3], t_we0, t_wa0, t_we1, t_wa1,
                 t_pset, t_paddr, t_clr, m_left);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset(string tag);
        rst_n = 1'b0;
        set_idle();
        model_reset();
        #1;
        check_all(tag);
        $display("[TB] %-12s reset asserted", tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 4; i++) t_addr[i] = $urandom_range(0, m_num - 1);
        t_we0   = 1'($urandom_range(0, 1));
        t_wa0   = $urandom_range(0, m_num - 1);
        t_wd0   = $urandom;
        t_we1   = 1'($urandom_range(0, 1));
        t_wa1   = ($urandom_range(0, 3) == 0) ? t_wa0 : $urandom_range(0, m_num - 1);
        t_wd1   = $urandom;
        t_pset  = ($urandom_range(0, 2) == 0);
        t_paddr = $urandom_range(0, m_num - 1);
        t_clr   = ($urandom_range(0, 40) == 0);
        t_pc    = $urandom;
    endtask

    task automatic fill_and_sweep();
        for (int r = 0; r < m_num - 1; r++) begin
            set_idle();
            t_we0 = 1'b1; t_wa0 = r; t_wd0 = 32'h100 + 32'(r) * 32'h11;
            step("fill");
        end
        set_idle(); t_pset = 1'b1; t_paddr = 7; t_addr[0] = 7;
        step("pset r7");
        set_idle(); t_clr = 1'b1;
        step("clr start");
        for (int c = 0; c < m_num + 1; c++) begin
            set_idle();
            t_addr[0] = 2; t_addr[1] = 7; t_addr[2] = c % m_num; t_addr[3] = (c + 5) % m_num;
            if (c == 0) begin t_we0 = 1'b1; t_wa0 = 2; t_wd0 = 32'hDEAD_BEEF; end
            if (c == 3) t_clr = 1'b1;
            if (c == 4) begin t_pset = 1'b1; t_paddr = 9; end
            step("sweep");
        end
        for (int a = 0; a < m_num; a += 4) begin
            set_idle();
            for (int i = 0; i < 4; i++) t_addr[i] = a + i;
            step("post clr");
        end
    endtask

    initial begin
        phase = 0; m_num = 16; m_pc = 15;
        for (int i = 0; i < 4; i++) t_addr[i] = 0;
        t_wa0 = 0; t_wa1 = 0; t_paddr = 0;
        t_wd0 = '0; t_wd1 = '0; t_pc = 32'h1234_5678;
        set_idle();
        @(negedge clk);
        do_reset("reset");

        set_idle(); t_we0 = 1'b1; t_wa0 = 2; t_wd0 = 42;                step("wr r2");
        set_idle(); t_we0 = 1'b1; t_wa0 = 3; t_wd0 = 77;                step("wr r3");
        set_idle(); t_addr[0] = 2; t_addr[1] = 3; t_addr[2] = 15;       step("rd r2 r3");
        set_idle(); t_we0 = 1'b1; t_wa0 = 15; t_wd0 = 999;              step("wr pc");
        set_idle(); t_pc = 32'h1234_5678;                               step("rd pc");

        set_idle(); t_we0 = 1'b1; t_wa0 = 4; t_wd0 = 1;
        t_we1 = 1'b1; t_wa1 = 4; t_wd1 = 2; t_addr[0] = 4;              step("wr prio");
        set_idle();                                                     step("rd r4");

        set_idle(); t_pset = 1'b1; t_paddr = 5; t_addr[0] = 5;          step("pset r5");
        set_idle();                                                     step("busy r5");
        set_idle(); t_we0 = 1'b1; t_wa0 = 5; t_wd0 = 3;                 step("alu r5");
        set_idle(); t_we1 = 1'b1; t_wa1 = 5; t_wd1 = 9;                 step("load r5");
        set_idle();                                                     step("clr r5");
        set_idle(); t_pset = 1'b1; t_paddr = 5;
        t_we1 = 1'b1; t_wa1 = 5; t_wd1 = 11;                            step("pset+load");
        set_idle();                                                     step("still busy");
        set_idle(); t_pset = 1'b1; t_paddr = 15; t_addr[1] = 15;        step("pset pc");
        set_idle();                                                     step("pc not busy");

        fill_and_sweep();

        set_idle(); t_we0 = 1'b1; t_wa0 = 6; t_wd0 = 32'h66;            step("wr r6");
        set_idle(); t_clr = 1'b1;                                       step("clr start");
        for (int c = 0; c < 6; c++) begin
            set_idle(); t_addr[0] = 6; t_addr[1] = c;                   step("sweep");
        end
        do_reset("reset mid");

        for (int n = 0; n < 250; n++) begin
            rand_inputs();
            step("rand16");
        end

        phase = 1; m_num = 32; m_pc = 31;
        do_reset("reset32");
        set_idle(); t_we0 = 1'b1; t_wa0 = 2; t_wd0 = 42;                step("wr r2");
        set_idle(); t_we0 = 1'b1; t_wa0 = 3; t_wd0 = 77;                step("wr r3");
        set_idle(); t_we0 = 1'b1; t_wa0 = 31; t_wd0 = 999;
        t_addr[0] = 2; t_addr[1] = 3; t_addr[2] = 31; t_addr[3] = 30;   step("wr pc");
        set_idle(); t_pc = 32'hCAFE_0031;                               step("rd pc");
        fill_and_sweep();
        for (int n = 0; n < 250; n++) begin
            rand_inputs();
            step("rand32");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
